score_scan_driver: RTL and testbench

- Upstream feeder for the 7-segment decoder stage. Accepts a binary game score and converts it to 4 BCD digits with a sequential double-dabble engine.
- Time-multiplexes the digits at a fixed refresh rate, presenting digit index, 4-bit digit value and dot flag each cycle to the decoder's SEG_SELECT_IN / BIN_IN / DOT_IN.

---
 rtl/score_scan_driver.sv | 163 ++++++++++++++++
 tb/tb_score_scan_driver.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/score_scan_driver.sv
// Binary score to 4-digit BCD (sequential double-dabble) with time-multiplexed digit scan.
// Optional: define SCORE_OVERFLOW_DOT_EN to light every dot while a clamped (9999) score is shown.
module score_scan_driver #(
   parameter int unsigned REFRESH_DIV = 100000,
   parameter int unsigned SCORE_W     = 14
) (
   input  logic               CLK,
   input  logic               RESET,
   input  logic [SCORE_W-1:0] SCORE_IN,
   input  logic               SCORE_VALID_IN,
   output logic               BUSY_OUT,
   output logic [3:0]         SEG_SELECT_OUT,
   output logic [3:0]         BIN_OUT,
   output logic               DOT_OUT
);

   localparam int unsigned     DivW    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int unsigned     CntW    = $clog2(SCORE_W + 1);
   localparam logic [DivW-1:0] DivLast = DivW'(REFRESH_DIV - 1);
   localparam logic [CntW-1:0] CntLast = CntW'(SCORE_W - 1);

   typedef enum logic [1:0] {StIdle, StShift, StCommit} state_e;

   state_e             state_q, state_d;
   logic [CntW-1:0]    cnt_q, cnt_d;
   logic [SCORE_W-1:0] bin_q, bin_d;
   logic [SCORE_W-1:0] pend_val_q, pend_val_d;
   logic [SCORE_W-1:0] in_val;
   logic [15:0]        bcd_q, bcd_d, bcd_adj;
   logic [15:0]        digits_q, digits_d;
   logic               pend_q, pend_d;
   logic               in_sat;
   logic [DivW-1:0]    div_q, div_d;
   logic [1:0]         idx_q, idx_d;
`ifdef SCORE_OVERFLOW_DOT_EN
   logic               conv_sat_q, conv_sat_d;
   logic               pend_sat_q, pend_sat_d;
   logic               dot_q, dot_d;
`endif

   assign in_sat = 32'(SCORE_IN) > 32'd9999;
   assign in_val = in_sat ? SCORE_W'(9999) : SCORE_IN;

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         bcd_adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3
                                                         : bcd_q[4*i +: 4];
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      bin_d      = bin_q;
      bcd_d      = bcd_q;
      digits_d   = digits_q;
      pend_d     = pend_q;
      pend_val_d = pend_val_q;
`ifdef SCORE_OVERFLOW_DOT_EN
      conv_sat_d = conv_sat_q;
      pend_sat_d = pend_sat_q;
      dot_d      = dot_q;
`endif
      unique case (state_q)
         StIdle: begin
            // A fresh strobe takes priority over a parked pending value.
            if (SCORE_VALID_IN || pend_q) begin
               state_d = StShift;
               cnt_d   = '0;
               bcd_d   = '0;
               pend_d  = 1'b0;
               bin_d   = SCORE_VALID_IN ? in_val : pend_val_q;
`ifdef SCORE_OVERFLOW_DOT_EN
               conv_sat_d = SCORE_VALID_IN ? in_sat : pend_sat_q;
`endif
            end
         end
         StShift: begin
            {bcd_d, bin_d} = {bcd_adj[14:0], bin_q, 1'b0};
            cnt_d          = cnt_q + CntW'(1);
            if (cnt_q == CntLast) state_d = StCommit;
         end
         StCommit: begin
            digits_d = bcd_q;
`ifdef SCORE_OVERFLOW_DOT_EN
            dot_d    = conv_sat_q;
`endif
            state_d  = StIdle;
         end
         default: state_d = StIdle;
      endcase
      if (SCORE_VALID_IN && (state_q != StIdle)) begin
         pend_d     = 1'b1;
         pend_val_d = in_val;
`ifdef SCORE_OVERFLOW_DOT_EN
         pend_sat_d = in_sat;
`endif
      end
   end

   // Scan prescaler runs freely, independent of any conversion.
   always_comb begin
      if (div_q == DivLast) begin
         div_d = '0;
         idx_d = idx_q + 2'd1;
      end else begin
         div_d = div_q + DivW'(1);
         idx_d = idx_q;
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         bin_q      <= '0;
         bcd_q      <= '0;
         digits_q   <= '0;
         pend_q     <= 1'b0;
         pend_val_q <= '0;
         div_q      <= '0;
         idx_q      <= '0;
`ifdef SCORE_OVERFLOW_DOT_EN
         conv_sat_q <= 1'b0;
         pend_sat_q <= 1'b0;
         dot_q      <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         bin_q      <= bin_d;
         bcd_q      <= bcd_d;
         digits_q   <= digits_d;
         pend_q     <= pend_d;
         pend_val_q <= pend_val_d;
         div_q      <= div_d;
         idx_q      <= idx_d;
`ifdef SCORE_OVERFLOW_DOT_EN
         conv_sat_q <= conv_sat_d;
         pend_sat_q <= pend_sat_d;
         dot_q      <= dot_d;
`endif
      end
   end

   always_comb begin
      unique case (idx_q)
         2'd0:    BIN_OUT = digits_q[3:0];
         2'd1:    BIN_OUT = digits_q[7:4];
         2'd2:    BIN_OUT = digits_q[11:8];
         default: BIN_OUT = digits_q[15:12];
      endcase
   end

   assign SEG_SELECT_OUT = {2'b00, idx_q};
   assign BUSY_OUT       = (state_q != StIdle);
`ifdef SCORE_OVERFLOW_DOT_EN
   assign DOT_OUT        = dot_q;
`else
   assign DOT_OUT        = 1'b0;
`endif

endmodule

// File: tb/tb_score_scan_driver.sv
// Bench for score_scan_driver: decimal-arithmetic reference model checked every cycle,
// directed scenarios with literal expectations, then randomized strobes and resets.
module tb_score_scan_driver;

   localparam int unsigned Div    = 4;
   localparam int unsigned ScoreW = 14;

   logic              clk = 1'b0;
   logic              rst;
   logic              valid;
   logic [ScoreW-1:0] score;
   logic              busy;
   logic [3:0]        seg;
   logic [3:0]        bin;
   logic              dot;

   always #5 clk = ~clk;

   score_scan_driver #(
      .REFRESH_DIV (Div),
      .SCORE_W     (ScoreW)
   ) u_dut (
      .CLK            (clk),
      .RESET          (rst),
      .SCORE_IN       (score),
      .SCORE_VALID_IN (valid),
      .BUSY_OUT       (busy),
      .SEG_SELECT_OUT (seg),
      .BIN_OUT        (bin),
      .DOT_OUT        (dot)
   );

   int n_cmp  = 0;
   int n_fail = 0;
   bit chk_en = 1'b0;

   // Model: displayed value, cycles left in the running conversion, pending slot, cycles since reset.
   int m_disp, m_disp_sat, m_left, m_conv, m_conv_sat, m_pend, m_pend_val, m_pend_sat, m_cyc;

   function automatic int clampv(int v);
      return (v > 9999) ? 9999 : v;
   endfunction

   function automatic int digit_of(int v, int i);
      int p = 1;
      for (int k = 0; k < i; k++) p = p * 10;
      return (v / p) % 10;
   endfunction

   function automatic int m_idx();
      return (m_cyc / Div) % 4;
   endfunction

   task automatic check(input string name, input int got, input int exp);
      n_cmp++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
      end
   endtask

   task automatic check_disp(input string name, input logic [15:0] lit);
      int i;
      i = m_idx();
      check(name, bin, lit[i*4 +: 4]);
   endtask

   task automatic model_step();
      bit idle;
      int v;
      if (rst) begin
         m_disp = 0; m_disp_sat = 0; m_left = 0; m_conv = 0; m_conv_sat = 0;
         m_pend = 0; m_pend_val = 0; m_pend_sat = 0; m_cyc = 0;
      end else begin
         m_cyc++;
         v    = int'(score);
         idle = (m_left == 0);
         if (m_left > 0) begin
            if (m_left == 1) begin
               m_disp     = m_conv;
               m_disp_sat = m_conv_sat;
            end
            m_left--;
         end
         if (idle) begin
            if (valid) begin
               m_conv = clampv(v); m_conv_sat = (v > 9999); m_left = 15; m_pend = 0;
            end else if (m_pend != 0) begin
               m_conv = m_pend_val; m_conv_sat = m_pend_sat; m_left = 15; m_pend = 0;
            end
         end else if (valid) begin
            m_pend = 1; m_pend_val = clampv(v); m_pend_sat = (v > 9999);
         end
      end
   endtask

   task automatic compare_all();
      int exp_dot;
`ifdef SCORE_OVERFLOW_DOT_EN
      exp_dot = m_disp_sat;
`else
      exp_dot = 0;
`endif
      check("seg_select", seg, m_idx());
      check("bin", bin, digit_of(m_disp, m_idx()));
      check("dot", dot, exp_dot);
      check("busy", busy, (m_left > 0) ? 1 : 0);
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
      if (chk_en) compare_all();
   endtask

   task automatic strobe(input int v);
      valid = 1'b1;
      score = ScoreW'(v);
      tick();
      valid = 1'b0;
   endtask

   initial begin
      int nbusy;
      rst   = 1'b1;
      valid = 1'b0;
      score = '0;
      tick();
      chk_en = 1'b1;
      tick();
      rst = 1'b0;

      // Reset state and idle scan
      check("rst_seg", seg, 0);
      check("rst_bin", bin, 0);
      check("rst_dot", dot, 0);
      check("rst_busy", busy, 0);
      repeat (4) tick();
      check("scan_step1", seg, 1);
      repeat (12) tick();
      check("scan_wrap", seg, 0);

      // 1234: busy for 15 cycles, digits 4/3/2/1
      strobe(1234);
      check("busy_start", busy, 1);
      repeat (14) tick();
      check("busy_last", busy, 1);
      tick();
      check("busy_drop", busy, 0);
      check_disp("d1234_first", 16'h1234);
      for (int i = 0; i < 16; i++) begin
         tick();
         check_disp("d1234", 16'h1234);
      end

      // 57 then 100, 42 mid-conversion: only 57 and 42 convert
      nbusy = 0;
      for (int i = 0; i < 45; i++) begin
         valid = (i == 0) || (i == 3) || (i == 5);
         score = (i == 0) ? 14'd57 : (i == 3) ? 14'd100 : 14'd42;
         tick();
         if (busy) nbusy++;
      end
      valid = 1'b0;
      check("two_conv_busy", nbusy, 30);
      check_disp("d0042", 16'h0042);

      // Overflow clamp
      strobe(16383);
      repeat (16) tick();
      check_disp("d9999", 16'h9999);
`ifdef SCORE_OVERFLOW_DOT_EN
      check("sat_dot", dot, 1);
`else
      check("sat_dot", dot, 0);
`endif
      strobe(5);
      repeat (16) tick();
      check_disp("d0005", 16'h0005);
      check("dot_clear", dot, 0);

      // Reset mid-conversion
      strobe(321);
      repeat (16) tick();
      check_disp("d0321", 16'h0321);
      strobe(8765);
      repeat (6) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("midrst_busy", busy, 0);
      check("midrst_seg", seg, 0);
      check("midrst_bin", bin, 0);
      repeat (20) tick();
      check_disp("midrst_d0000", 16'h0000);

      // Strobe landing on the COMMIT cycle of a prior conversion
      strobe(11);
      repeat (14) tick();
      valid = 1'b1;
      score = 14'd22;
      tick();
      valid = 1'b0;
      check("cmt_busy_gap", busy, 0);
      check_disp("d0011", 16'h0011);
      tick();
      check("cmt_busy_again", busy, 1);
      repeat (14) tick();
      check("cmt_busy_last", busy, 1);
      tick();
      check("cmt_busy_done", busy, 0);
      check_disp("d0022", 16'h0022);

      // Randomized strobes and resets against the model
      for (int i = 0; i < 3000; i++) begin
         valid = ($urandom_range(0, 7) == 0);
         score = ($urandom_range(0, 3) == 0) ? ScoreW'($urandom_range(9990, 16383))
                                             : ScoreW'($urandom_range(0, 9999));
         rst   = ($urandom_range(0, 299) == 0);
         tick();
      end
      valid = 1'b0;
      rst   = 1'b0;
      repeat (40) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
